aes_key_schedule: RTL and testbench

Sequential AES key-expansion engine that sits directly upstream of the `Decryption` datapath and supplies its round keys. It samples a cipher key on a start pulse and generates one 32-bit schedule word per clock into an internal round-key store. It raises `done` when the full schedule is valid. The decryption stage reads keys by round index in any order; its final-round-first use needs no reordering here.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_schedule.sv | 116 +++++++++++
 tb/tb_aes_key_schedule.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, legal key/round pairings,
// GF(2^8) helpers for the round constant, and the 32-bit word type.
package aes_pkg;

    localparam int AES_NB = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } ks_state_t;

    // Round count that goes with a given key length (4/6/8 -> 10/12/14).
    function automatic int nr_for_nk(input int nk);
        return nk + 6;
    endfunction

    function automatic bit legal_cfg(input int nk, input int nr);
        return ((nk == 4) || (nk == 6) || (nk == 8)) && (nr == nr_for_nk(nk));
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rcon[j] for j >= 1: 01, 02, 04, ... 80, 1b, 36, ...
    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k <= 15; k++) begin
            if (k <= int'(j)) r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. Shared with the encryption datapath.
module aes_sbox (
    input  logic [7:0] b,
    output logic [7:0] s
);
    // Byte 0x00 occupies the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255 - b) * 8, i.e. (~b) * 8.
    always_comb begin
        s = SBOX_TBL[{~b, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion: loads the cipher key on start, then produces
// one schedule word per clock into a round-key store read by round index.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int Nb = AES_NB,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              done,
    input  logic [3:0]        rk_rd_addr,
    output logic [127:0]      rk_rd_data
);
    localparam int         W    = Nb * (Nr + 1);
    localparam logic [5:0] LAST = 6'(W - 1);
    localparam logic [5:0] NK_W = 6'(Nk);

    if (!legal_cfg(Nk, Nr)) begin : g_bad_cfg
        $error("aes_key_schedule: illegal Nk/Nr pairing");
    end

    ks_state_t  state, state_nx;
    logic       load;
    logic [5:0] i;
    word_t      w [W];

    logic [5:0] prev_idx, back_idx;
    logic [2:0] kmod;
    logic [3:0] rcon_idx;
    word_t      prev_w, back_w, sub_w, temp_w, new_w;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // FSM next-state: start is ignored while expanding
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_EXPAND;
            S_EXPAND: if (i == LAST) state_nx = S_DONE;
            S_DONE:   if (start) state_nx = S_EXPAND;
            default:  state_nx = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_EXPAND);
        done = (state == S_DONE);
        load = start && (state != S_EXPAND);
    end

    // Word index: starts at Nk after a load, advances once per expansion cycle
    always_ff @(posedge clk) begin
        if (reset)                    i <= '0;
        else if (load)                i <= NK_W;
        else if (state == S_EXPAND)   i <= i + 6'd1;
    end

    // Round-key store: cleared by reset, key words on load, one new word per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < W; k++) w[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < Nk; k++) w[k] <= key[32*(Nk-1-k) +: 32];
        end else if (state == S_EXPAND) begin
            w[i] <= new_w;
        end
    end

    // Operand selection; indices are clamped so idle-state reads stay in range
    always_comb begin
        prev_idx = (i == 6'd0) ? 6'd0 : i - 6'd1;
        back_idx = (i < NK_W)  ? 6'd0 : i - NK_W;
        prev_w   = w[prev_idx];
        back_w   = w[back_idx];
        kmod     = 3'(i % NK_W);
        rcon_idx = 4'(i / NK_W);
    end

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .b (prev_w[8*g +: 8]),
            .s (sub_w[8*g +: 8])
        );
    end

    // Word rule. SubWord is bytewise, so rotating after substitution equals
    // SubWord(RotWord(temp)) and lets one set of S-boxes serve both cases.
    always_comb begin
        if (kmod == 3'd0)
            temp_w = {sub_w[23:0], sub_w[31:24]} ^ {rcon(rcon_idx), 24'h0};
        else if ((Nk == 8) && (kmod == 3'd4))
            temp_w = sub_w;
        else
            temp_w = prev_w;
        new_w = back_w ^ temp_w;
    end

    // Combinational round-key read; out-of-range rounds read as zero
    always_comb begin
        rk_rd_data = '0;
        if ({28'd0, rk_rd_addr} <= 32'(Nr))
            rk_rd_data = {w[{rk_rd_addr, 2'd0}], w[{rk_rd_addr, 2'd1}],
                          w[{rk_rd_addr, 2'd2}], w[{rk_rd_addr, 2'd3}]};
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule (Nk=4 and Nk=8 instances).
`timescale 1ns/1ps
module tb_aes_key_schedule;

    typedef struct {
        logic [127:0] rk [15];
        int           nr;
        int           e0;
        int           lat;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic         reset = 1'b1;
    logic         start4 = 1'b0, start8 = 1'b0;
    logic [127:0] key4 = '0;
    logic [255:0] key8 = '0;
    logic         busy4, done4, busy8, done8;
    logic [3:0]   rd4, rd8;
    logic [3:0]   saddr4 = '0, maddr4 = '0, saddr8 = '0, maddr8 = '0;
    logic         sel4 = 1'b0, sel8 = 1'b0;
    logic [127:0] rdat4, rdat8;

    assign rd4 = sel4 ? saddr4 : maddr4;
    assign rd8 = sel8 ? saddr8 : maddr8;

    aes_key_schedule #(.Nb(4), .Nk(4), .Nr(10)) u4 (
        .clk(clk), .reset(reset), .start(start4), .key(key4),
        .busy(busy4), .done(done4), .rk_rd_addr(rd4), .rk_rd_data(rdat4)
    );

    aes_key_schedule #(.Nb(4), .Nk(8), .Nr(14)) u8 (
        .clk(clk), .reset(reset), .start(start8), .key(key8),
        .busy(busy8), .done(done8), .rk_rd_addr(rd8), .rk_rd_data(rdat8)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int next_id = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- GF(2^8) reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[a]  = s;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key expansion straight from the word rule; key is right-aligned in k.
    task automatic model(input logic [255:0] k, input int nk, output exp_t e);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr, tot;
        nr  = nk + 6;
        tot = 4 * (nr + 1);
        rc  = 8'h01;
        for (int j = 0; j < nk; j++) w[j] = k[32*(nk-1-j) +: 32];
        for (int i = nk; i < tot; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            e.rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        e.nr  = nr;
        e.lat = tot - nk;
        e.id  = next_id;
        e.e0  = 0;
        next_id++;
    endtask

    // ---------------- inverse cipher for the hand-off check ----------------
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = isb[s[127-8*n -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    // ---------------- monitors ----------------
    initial begin : mon4
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done4 === 1'b1 && prev === 1'b0) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL nk4_unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
                end else begin
                    e = q4.pop_front();
                    chk($sformatf("nk4_t%0d_latency", e.id), 128'(cyc - e.e0), 128'(e.lat));
                    for (int r = 0; r <= e.nr + 1; r++) begin
                        maddr4 = 4'(r);
                        #1;
                        chk($sformatf("nk4_t%0d_rk%0d", e.id, r), rdat4, e.rk[r]);
                    end
                end
            end
            prev = done4;
        end
    end

    initial begin : mon8
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done8 === 1'b1 && prev === 1'b0) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL nk8_unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
                end else begin
                    e = q8.pop_front();
                    chk($sformatf("nk8_t%0d_latency", e.id), 128'(cyc - e.e0), 128'(e.lat));
                    for (int r = 0; r <= e.nr + 1; r++) begin
                        maddr8 = 4'(r);
                        #1;
                        chk($sformatf("nk8_t%0d_rk%0d", e.id, r), rdat8, e.rk[r]);
                    end
                end
            end
            prev = done8;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Pulse start around one edge (E0); returns at the falling edge after E0.
    task automatic issue4(input logic [127:0] k, input bit push, output int e0);
        exp_t e;
        @(negedge clk);
        start4 = 1'b1;
        key4   = k;
        @(negedge clk);
        start4 = 1'b0;
        e0 = cyc;
        if (push) begin
            model({128'h0, k}, 4, e);
            e.e0 = e0;
            q4.push_back(e);
        end
    endtask

    task automatic issue8(input logic [255:0] k, output int e0);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        key8   = k;
        @(negedge clk);
        start8 = 1'b0;
        e0 = cyc;
        model(k, 8, e);
        e.e0 = e0;
        q8.push_back(e);
    endtask

    task automatic wait_done4(input int maxc, input string nm);
        int n;
        n = 0;
        while (done4 !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (done4 !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s_timeout: got done=%b expected 1 within %0d cycles", nm, done4, maxc);
        end
        @(negedge clk);
    endtask

    task automatic wait_done8(input int maxc, input string nm);
        int n;
        n = 0;
        while (done8 !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s_timeout: got done=%b expected 1 within %0d cycles", nm, done8, maxc);
        end
        @(negedge clk);
    endtask

    task automatic rd_rk4(input int r, output logic [127:0] d);
        sel4   = 1'b1;
        saddr4 = 4'(r);
        #1;
        d = rdat4;
        sel4 = 1'b0;
    endtask

    task automatic rd_rk8(input int r, output logic [127:0] d);
        sel8   = 1'b1;
        saddr8 = 4'(r);
        #1;
        d = rdat8;
        sel8 = 1'b0;
    endtask

    task automatic check_cleared(input string nm);
        logic [127:0] d;
        chk({nm, "_busy4"}, 128'(busy4), 128'(0));
        chk({nm, "_done4"}, 128'(done4), 128'(0));
        chk({nm, "_busy8"}, 128'(busy8), 128'(0));
        chk({nm, "_done8"}, 128'(done8), 128'(0));
        for (int r = 0; r < 16; r++) begin
            rd_rk4(r, d);
            chk($sformatf("%s_nk4_rk%0d", nm, r), d, 128'h0);
        end
        for (int r = 0; r < 16; r += 5) begin
            rd_rk8(r, d);
            chk($sformatf("%s_nk8_rk%0d", nm, r), d, 128'h0);
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        int e0;
        logic [127:0] d, st, rk [11];
        logic [127:0] k4;
        logic [255:0] k8;

        build_sbox();

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_cleared("reset");

        // FIPS-197 128-bit key
        issue4(128'h000102030405060708090a0b0c0d0e0f, 1'b1, e0);
        chk("fips128_busy_after_e0", 128'(busy4), 128'(1));
        wait_done4(60, "fips128");
        rd_rk4(0, d);  chk("fips128_round0",  d, 128'h000102030405060708090a0b0c0d0e0f);
        rd_rk4(1, d);  chk("fips128_round1",  d, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rd_rk4(10, d); chk("fips128_round10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd_rk4(11, d); chk("fips128_addr11",  d, 128'h0);
        chk("fips128_busy_done", 128'(busy4), 128'(0));

        // Hand-off: inverse cipher driven by the DUT's round keys
        for (int r = 0; r <= 10; r++) rd_rk4(r, rk[r]);
        st = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ rk[10];
        for (int r = 9; r >= 1; r--) st = inv_mix(inv_sub(inv_shift(st)) ^ rk[r]);
        st = inv_sub(inv_shift(st)) ^ rk[0];
        chk("handoff_plaintext", st, 128'h00112233445566778899aabbccddeeff);

        // Back-to-back restart from DONE
        issue4(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, e0);
        chk("restart_done_low_after_e0", 128'(done4), 128'(0));
        chk("restart_busy_after_e0",     128'(busy4), 128'(1));
        wait_done4(60, "restart");
        rd_rk4(10, d); chk("restart_round10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // FIPS-197 256-bit key
        issue8(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, e0);
        wait_done8(80, "fips256");
        rd_rk8(14, d); chk("fips256_round14", d, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_rk8(15, d); chk("fips256_addr15",  d, 128'h0);

        // Reset sampled at E20 aborts the expansion
        k4 = {$urandom, $urandom, $urandom, $urandom};
        issue4(k4, 1'b0, e0);
        while (cyc < e0 + 19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("abort");
        repeat (50) @(negedge clk);
        chk("abort_done_stays_low", 128'(done4), 128'(0));

        // Second start mid-expansion and key changes after E0 are ignored
        k4 = {$urandom, $urandom, $urandom, $urandom};
        issue4(k4, 1'b1, e0);
        key4 = ~k4;
        while (cyc < e0 + 9) @(negedge clk);
        start4 = 1'b1;
        key4   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start4 = 1'b0;
        key4   = '0;
        wait_done4(60, "midstart");

        // Randomized keys
        for (int n = 0; n < 6; n++) begin
            k4 = {$urandom, $urandom, $urandom, $urandom};
            issue4(k4, 1'b1, e0);
            key4 = {$urandom, $urandom, $urandom, $urandom};
            wait_done4(60, "rand128");
        end
        for (int n = 0; n < 3; n++) begin
            k8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            issue8(k8, e0);
            key8 = ~k8;
            wait_done8(80, "rand256");
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_nk4_drained", 128'(q4.size()), 128'(0));
        chk("scoreboard_nk8_drained", 128'(q8.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
